// File: rtl/io_pkg.sv
// Shared definitions for the output-side I/O stage: UART transmitter states and line constants.
package io_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic TXD_IDLE       = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data and async active-low reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_tx_unit.sv
// Output I/O stage: buffers pipeline output bytes in a FIFO and serialises them as UART frames.
// Optional even parity bit is enabled by defining IO_TX_PARITY_EN.
module io_tx_unit
    import io_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     out_issued,
    input  logic [31:0]              out_data,
    output logic                     out_stall,
    output logic                     txd,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    tx_state_t                 state, state_next;
    logic [BAUD_W-1:0]         baud_cnt, baud_next;
    logic [IDX_W-1:0]          bit_idx, bit_idx_next;
    logic [UART_DATA_BITS-1:0] sr, sr_next;
    logic                      txd_next;
    logic                      bit_end;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic [23:0]               unused_data_hi;
`ifdef IO_TX_PARITY_EN
    logic                      par_bit, par_next;
`endif

    assign unused_data_hi = out_data[31:8];

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_issued),
        .pop   (fifo_pop),
        .din   (out_data[UART_DATA_BITS-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_stall = fifo_full;
    assign tx_busy   = (state != IDLE) || (fifo_count != '0);
    assign bit_end   = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            sr       <= '0;
            txd      <= TXD_IDLE;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_idx_next;
            sr       <= sr_next;
            txd      <= txd_next;
        end
    end

`ifdef IO_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit <= 1'b0;
        end else begin
            par_bit <= par_next;
        end
    end
`endif

    // txd is registered from the next state so the line never glitches between bits.
    always_comb begin
        state_next   = state;
        baud_next    = '0;
        bit_idx_next = bit_idx;
        sr_next      = sr;
        fifo_pop     = 1'b0;
        txd_next     = TXD_IDLE;
`ifdef IO_TX_PARITY_EN
        par_next     = par_bit;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    sr_next    = fifo_dout;
                    state_next = START;
`ifdef IO_TX_PARITY_EN
                    par_next   = ^fifo_dout;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    sr_next      = sr >> 1;
                    bit_idx_next = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_LAST) begin
`ifdef IO_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
`ifdef IO_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        sr_next    = fifo_dout;
                        state_next = START;
`ifdef IO_TX_PARITY_EN
                        par_next   = ^fifo_dout;
`endif
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = sr_next[0];
`ifdef IO_TX_PARITY_EN
            PARITY:  txd_next = par_next;
`endif
            default: txd_next = TXD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_io_tx_unit.sv
// Directed self-checking bench for io_tx_unit with DEPTH=4 and CLKS_PER_BIT=4.
// Build with IO_TX_PARITY_EN defined to exercise the parity frame format.
module tb_io_tx_unit;

    localparam int DEPTH     = 4;
    localparam int CPB       = 4;
    localparam int DATA_BITS = 8;
`ifdef IO_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk;
    logic        rst;
    logic        out_issued;
    logic [31:0] out_data;
    logic        out_stall;
    logic        txd;
    logic        tx_busy;
    logic [2:0]  fifo_count;

    int compared;
    int mismatched;

    io_tx_unit #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .out_issued (out_issued),
        .out_data   (out_data),
        .out_stall  (out_stall),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; pushes for exactly one rising edge and returns on the next falling edge.
    task automatic applyStimulus(input logic [31:0] data);
        checkOutput("push_while_full", {31'b0, out_stall}, 32'd0);
        out_issued = 1'b1;
        out_data   = data;
        @(negedge clk);
        out_issued = 1'b0;
        out_data   = 32'd0;
    endtask

    // Starts on the first cycle of the start bit and ends on the first cycle after the stop bit.
    task automatic checkFrame(input logic [7:0] b, input string tag);
        logic exp_bit;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (i == 0)
                exp_bit = 1'b0;
            else if (i <= DATA_BITS)
                exp_bit = b[i-1];
            else if (i == FRAME_BITS - 1)
                exp_bit = 1'b1;
            else
                exp_bit = ^b;
            for (int c = 0; c < CPB; c++) begin
                checkOutput($sformatf("%s_bit%0d_c%0d", tag, i, c), {31'b0, txd}, {31'b0, exp_bit});
                @(negedge clk);
            end
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_txd"},   {31'b0, txd},       32'd1);
        checkOutput({tag, "_busy"},  {31'b0, tx_busy},   32'd0);
        checkOutput({tag, "_count"}, {29'b0, fifo_count}, 32'd0);
        checkOutput({tag, "_stall"}, {31'b0, out_stall}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        out_issued = 1'b0;
        out_data   = 32'd0;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkIdle("reset");
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] single byte 0x55");
        applyStimulus(32'h0000_0055);
        checkOutput("single_count", {29'b0, fifo_count}, 32'd1);
        checkOutput("single_txd_before", {31'b0, txd}, 32'd1);
        checkOutput("single_busy", {31'b0, tx_busy}, 32'd1);
        @(negedge clk);
        checkOutput("single_start_latency", {31'b0, txd}, 32'd0);
        checkFrame(8'h55, "f55");
        checkIdle("after_55");

        $display("[TB] upper data bits ignored");
        applyStimulus(32'hFFFF_FF55);
        @(negedge clk);
        checkFrame(8'h55, "fff55");
        checkIdle("after_ff55");

        $display("[TB] fill and stall");
        // Byte 0x01 is popped the cycle after it lands, so a fifth push is needed to fill four entries.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(32'(k));
        end
        checkOutput("fill_count_full", {29'b0, fifo_count}, 32'd4);
        checkOutput("fill_stall_set", {31'b0, out_stall}, 32'd1);
        checkOutput("fill_f1_start", {31'b0, txd}, 32'd0);
        repeat (36) @(negedge clk);
        checkOutput("fill_last_stop_count", {29'b0, fifo_count}, 32'd4);
        checkOutput("fill_last_stop_stall", {31'b0, out_stall}, 32'd1);
        checkOutput("fill_last_stop_txd", {31'b0, txd}, 32'd1);
        @(negedge clk);
        checkOutput("fill_pop_count", {29'b0, fifo_count}, 32'd3);
        checkOutput("fill_pop_stall", {31'b0, out_stall}, 32'd0);
        for (int k = 2; k <= 5; k++) begin
            checkFrame(8'(k), $sformatf("fill%0d", k));
        end
        checkIdle("after_fill");

        $display("[TB] push on the pop cycle");
        applyStimulus(32'h11);
        applyStimulus(32'h22);
        applyStimulus(32'h33);
        checkOutput("pp_queued", {29'b0, fifo_count}, 32'd2);
        repeat (38) @(negedge clk);
        checkOutput("pp_pre_count", {29'b0, fifo_count}, 32'd2);
        checkOutput("pp_pre_txd", {31'b0, txd}, 32'd1);
        applyStimulus(32'h44);
        checkOutput("pp_post_count", {29'b0, fifo_count}, 32'd2);
        checkFrame(8'h22, "pp22");
        checkFrame(8'h33, "pp33");
        checkFrame(8'h44, "pp44");
        checkIdle("after_pp");

        $display("[TB] reset mid-frame");
        applyStimulus(32'hA5);
        applyStimulus(32'h5A);
        checkOutput("mid_start", {31'b0, txd}, 32'd0);
        checkOutput("mid_count", {29'b0, fifo_count}, 32'd1);
        repeat (17) @(negedge clk);
        checkOutput("mid_bit3", {31'b0, txd}, 32'd0);
        #2 rst = 1'b0;
        #1;
        checkIdle("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checkOutput($sformatf("mid_quiet%0d", k), {31'b0, txd}, 32'd1);
        end
        checkIdle("after_mid");

        $display("[TB] parity-sensitive bytes");
        applyStimulus(32'h07);
        @(negedge clk);
        checkFrame(8'h07, "f07");
        checkIdle("after_07");
        applyStimulus(32'h03);
        @(negedge clk);
        checkFrame(8'h03, "f03");
        checkIdle("after_03");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
